// File: rtl/seq_chk_pkg.sv
// Shared helpers for the sequence-chain checker: parameter sanity,
// stage-index width and a width-generic saturating add.
package seq_chk_pkg;

    function automatic bit params_ok(input int num_stages, input int dly, input int cw);
        return (num_stages >= 1) && (dly >= 1) && (cw >= 1) && (cw <= 64);
    endfunction

    // A single-stage chain still needs one bit to carry a stage index.
    function automatic int stage_idx_w(input int num_stages);
        return (num_stages <= 1) ? 1 : $clog2(num_stages);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/seq_chain_checker_sat_counter.sv
// Saturating up-counter with a multi-bit increment; holds at all-ones.
module sat_counter
    import seq_chk_pkg::*;
#(
    parameter int W  = 16,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic [IW-1:0] inc_i,
    output logic [W-1:0]  cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = W'(sat_add(64'(cnt_q), 64'(inc_i), W));
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_chain_checker.sv
// Monitor for trig |-> ##DLY ev[0] ##DLY ev[1] ... ##DLY ev[N-1] with fully
// overlapping attempts, per-stage failure flags, counters and first-failure capture.
module seq_chain_checker
    import seq_chk_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int DLY        = 1,
    parameter int CW         = 16,
    parameter int TW         = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  clr,
    input  logic                                  trig,
    input  logic [NUM_STAGES-1:0]                 ev,
    output logic                                  pass_o,
    output logic                                  fail_o,
    output logic [NUM_STAGES-1:0]                 fail_stage_o,
    output logic [CW-1:0]                         pass_cnt_o,
    output logic [CW-1:0]                         fail_cnt_o,
    output logic                                  ff_valid_o,
    output logic [stage_idx_w(NUM_STAGES)-1:0]    ff_stage_o,
    output logic [TW-1:0]                         ff_start_o
);

    localparam int D  = NUM_STAGES * DLY;
    localparam int SW = stage_idx_w(NUM_STAGES);
    localparam int PW = $clog2(NUM_STAGES + 1);

    if (!params_ok(NUM_STAGES, DLY, CW)) begin : g_param_err
        $error("seq_chain_checker: NUM_STAGES, DLY, CW must be >= 1 and CW <= 64");
    end

    logic [TW-1:0]         stamp_q, stamp_d;
    logic [D-1:0]          valid_q, valid_d;
    logic [TW-1:0]         start_q [D];
    logic [TW-1:0]         start_d [D];
    logic [D-1:0]          chk_fail;
    logic [NUM_STAGES-1:0] fail_vec;
    logic [PW-1:0]         fail_pop;
    logic                  pass_now;
    logic                  start;

    logic                  pass_q;
    logic                  fail_q;
    logic [NUM_STAGES-1:0] fail_stage_q;
    logic                  ff_valid_q, ff_valid_d;
    logic [SW-1:0]         ff_stage_q, ff_stage_d;
    logic [TW-1:0]         ff_start_q, ff_start_d;

    // Slot k holds the attempt triggered k+1 edges ago; stage i checks slot (i+1)*DLY-1.
    always_comb begin
        start    = trig && en && !clr;
        stamp_d  = stamp_q + TW'(1);
        chk_fail = '0;
        fail_vec = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (valid_q[(i+1)*DLY-1] && !ev[i]) begin
                fail_vec[i]             = 1'b1;
                chk_fail[(i+1)*DLY-1]   = 1'b1;
            end
        end
        pass_now = valid_q[D-1] && ev[NUM_STAGES-1];

        valid_d    = '0;
        valid_d[0] = start;
        start_d[0] = stamp_d;
        for (int k = 1; k < D; k++) begin
            valid_d[k] = valid_q[k-1] && !chk_fail[k-1];
            start_d[k] = start_q[k-1];
        end

        fail_pop = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            fail_pop = fail_pop + PW'(fail_vec[i]);
        end

        ff_valid_d = ff_valid_q;
        ff_stage_d = ff_stage_q;
        ff_start_d = ff_start_q;
        if (!ff_valid_q && (|fail_vec)) begin
            ff_valid_d = 1'b1;
            // Descending scan so the lowest failing stage wins.
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (fail_vec[i]) begin
                    ff_stage_d = SW'(i);
                    ff_start_d = start_q[(i+1)*DLY-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_q      <= '0;
            valid_q      <= '0;
            for (int k = 0; k < D; k++) start_q[k] <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_stage_q <= '0;
            ff_valid_q   <= 1'b0;
            ff_stage_q   <= '0;
            ff_start_q   <= '0;
        end else begin
            stamp_q <= stamp_d;
            if (clr) begin
                valid_q      <= '0;
                for (int k = 0; k < D; k++) start_q[k] <= '0;
                pass_q       <= 1'b0;
                fail_q       <= 1'b0;
                fail_stage_q <= '0;
                ff_valid_q   <= 1'b0;
                ff_stage_q   <= '0;
                ff_start_q   <= '0;
            end else begin
                valid_q      <= valid_d;
                for (int k = 0; k < D; k++) start_q[k] <= start_d[k];
                pass_q       <= pass_now;
                fail_q       <= |fail_vec;
                fail_stage_q <= fail_vec;
                ff_valid_q   <= ff_valid_d;
                ff_stage_q   <= ff_stage_d;
                ff_start_q   <= ff_start_d;
            end
        end
    end

    sat_counter #(.W(CW), .IW(1)) u_pass_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (pass_now),
        .cnt_o (pass_cnt_o)
    );

    sat_counter #(.W(CW), .IW(PW)) u_fail_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (fail_pop),
        .cnt_o (fail_cnt_o)
    );

    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign fail_stage_o = fail_stage_q;
    assign ff_valid_o   = ff_valid_q;
    assign ff_stage_o   = ff_stage_q;
    assign ff_start_o   = ff_start_q;

endmodule

// File: tb/tb_seq_chain_checker.sv
// Directed bench: vector table on N=2/DLY=1 (plus a CW=2 twin), then hand
// sequences on an N=3/DLY=2 instance.
module tb_seq_chain_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, clr, trig;
    logic [1:0] ev;
    logic [2:0] ev3;

    logic        m_pass, m_fail, m_ffv, m_ffs;
    logic [1:0]  m_stage;
    logic [15:0] m_pcnt, m_fcnt;
    logic [31:0] m_ffst;

    logic        s_pass, s_fail, s_ffv, s_ffs;
    logic [1:0]  s_stage, s_pcnt, s_fcnt;
    logic [31:0] s_ffst;

    logic        l_pass, l_fail, l_ffv;
    logic [2:0]  l_stage;
    logic [1:0]  l_ffs;
    logic [15:0] l_pcnt, l_fcnt;
    logic [31:0] l_ffst;

    seq_chain_checker #(.NUM_STAGES(2), .DLY(1), .CW(16), .TW(32)) u_main (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .ev(ev),
        .pass_o(m_pass), .fail_o(m_fail), .fail_stage_o(m_stage),
        .pass_cnt_o(m_pcnt), .fail_cnt_o(m_fcnt), .ff_valid_o(m_ffv),
        .ff_stage_o(m_ffs), .ff_start_o(m_ffst));

    seq_chain_checker #(.NUM_STAGES(2), .DLY(1), .CW(2), .TW(32)) u_sat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .ev(ev),
        .pass_o(s_pass), .fail_o(s_fail), .fail_stage_o(s_stage),
        .pass_cnt_o(s_pcnt), .fail_cnt_o(s_fcnt), .ff_valid_o(s_ffv),
        .ff_stage_o(s_ffs), .ff_start_o(s_ffst));

    seq_chain_checker #(.NUM_STAGES(3), .DLY(2), .CW(16), .TW(32)) u_long (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .trig(trig), .ev(ev3),
        .pass_o(l_pass), .fail_o(l_fail), .fail_stage_o(l_stage),
        .pass_cnt_o(l_pcnt), .fail_cnt_o(l_fcnt), .ff_valid_o(l_ffv),
        .ff_stage_o(l_ffs), .ff_start_o(l_ffst));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, clr, en, trig;
        logic [1:0]  ev;
        logic        pass, fail;
        logic [1:0]  stage;
        logic [15:0] pcnt, fcnt;
        logic        ffv, ffs;
        logic [31:0] ffst;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, input logic c, input logic e, input logic t,
                              input logic [1:0] evv, input logic p, input logic f,
                              input logic [1:0] st, input logic [15:0] pc, input logic [15:0] fc,
                              input logic fv, input logic fs, input logic [31:0] fst);
        vec_t x;
        x.rst = r; x.clr = c; x.en = e; x.trig = t; x.ev = evv;
        x.pass = p; x.fail = f; x.stage = st; x.pcnt = pc; x.fcnt = fc;
        x.ffv = fv; x.ffs = fs; x.ffst = fst;
        tbl.push_back(x);
    endfunction

    // Zero-output row: inputs only.
    function automatic void z(input logic r, input logic c, input logic e, input logic t,
                              input logic [1:0] evv);
        v(r, c, e, t, evv, 0, 0, 2'b00, 16'd0, 16'd0, 0, 0, 32'd0);
    endfunction

    function automatic logic [1:0] sat2(input logic [15:0] x);
        return (x > 16'd3) ? 2'd3 : x[1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; trig = 1'b0; ev = 2'b00; ev3 = 3'b000;
        repeat (2) tick();

        // ev = {c, b}; each row: inputs before an edge, outputs after it.
        // Single pass, then pulse drops.
        z(1,0,1,0,2'b00);
        z(0,0,1,1,2'b00);
        z(0,0,1,0,2'b01);
        v(0,0,1,0,2'b10, 1,0,2'b00, 16'd1,16'd0, 0,0,32'd0);
        v(0,0,1,0,2'b00, 0,0,2'b00, 16'd1,16'd0, 0,0,32'd0);
        // Stage-0 failure, stage 1 not checked afterwards.
        z(1,0,1,0,2'b00);
        z(0,0,1,1,2'b00);
        v(0,0,1,0,2'b10, 0,1,2'b01, 16'd0,16'd1, 1,0,32'd1);
        v(0,0,1,0,2'b10, 0,0,2'b00, 16'd0,16'd1, 1,0,32'd1);
        // Two failures on one edge, then clr kills in-flight work and blocks a trigger.
        z(1,0,1,0,2'b00);
        z(0,0,1,1,2'b00);
        z(0,0,1,1,2'b01);
        v(0,0,1,0,2'b00, 0,1,2'b11, 16'd0,16'd2, 1,0,32'd2);
        v(0,0,1,0,2'b00, 0,0,2'b00, 16'd0,16'd2, 1,0,32'd2);
        v(0,0,1,1,2'b00, 0,0,2'b00, 16'd0,16'd2, 1,0,32'd2);
        z(0,1,1,0,2'b11);
        z(0,0,1,0,2'b11);
        z(0,1,1,1,2'b11);
        z(0,0,1,0,2'b11);
        z(0,0,1,0,2'b11);
        z(0,0,1,1,2'b00);
        v(0,0,1,0,2'b00, 0,1,2'b01, 16'd0,16'd1, 1,0,32'd11);
        // en=0 blocks starts only; later stage-1 failure keeps first capture.
        z(1,0,1,0,2'b00);
        z(0,0,0,1,2'b00);
        z(0,0,0,1,2'b00);
        z(0,0,0,1,2'b00);
        z(0,0,0,1,2'b00);
        z(0,0,1,1,2'b00);
        v(0,0,0,1,2'b00, 0,1,2'b01, 16'd0,16'd1, 1,0,32'd5);
        v(0,0,1,1,2'b00, 0,0,2'b00, 16'd0,16'd1, 1,0,32'd5);
        v(0,0,1,0,2'b01, 0,0,2'b00, 16'd0,16'd1, 1,0,32'd5);
        v(0,0,1,0,2'b00, 0,1,2'b10, 16'd0,16'd2, 1,0,32'd5);
        // Back-to-back passes on consecutive edges.
        z(1,0,1,0,2'b00);
        z(0,0,1,1,2'b00);
        z(0,0,1,1,2'b01);
        v(0,0,1,0,2'b11, 1,0,2'b00, 16'd1,16'd0, 0,0,32'd0);
        v(0,0,1,0,2'b10, 1,0,2'b00, 16'd2,16'd0, 0,0,32'd0);
        v(0,0,1,0,2'b00, 0,0,2'b00, 16'd2,16'd0, 0,0,32'd0);
        // Five failing attempts (CW=2 twin saturates at 3), then one pass.
        z(1,0,1,0,2'b00);
        z(0,0,1,1,2'b00);
        v(0,0,1,1,2'b00, 0,1,2'b01, 16'd0,16'd1, 1,0,32'd1);
        v(0,0,1,1,2'b00, 0,1,2'b01, 16'd0,16'd2, 1,0,32'd1);
        v(0,0,1,1,2'b00, 0,1,2'b01, 16'd0,16'd3, 1,0,32'd1);
        v(0,0,1,1,2'b00, 0,1,2'b01, 16'd0,16'd4, 1,0,32'd1);
        v(0,0,1,0,2'b00, 0,1,2'b01, 16'd0,16'd5, 1,0,32'd1);
        v(0,0,1,1,2'b00, 0,0,2'b00, 16'd0,16'd5, 1,0,32'd1);
        v(0,0,1,0,2'b01, 0,0,2'b00, 16'd0,16'd5, 1,0,32'd1);
        v(0,0,1,0,2'b10, 1,0,2'b00, 16'd1,16'd5, 1,0,32'd1);

        for (int j = 0; j < tbl.size(); j++) begin
            rst = tbl[j].rst; clr = tbl[j].clr; en = tbl[j].en;
            trig = tbl[j].trig; ev = tbl[j].ev;
            tick();
            chk($sformatf("v%0d pass", j),  32'(m_pass),  32'(tbl[j].pass));
            chk($sformatf("v%0d fail", j),  32'(m_fail),  32'(tbl[j].fail));
            chk($sformatf("v%0d stage", j), 32'(m_stage), 32'(tbl[j].stage));
            chk($sformatf("v%0d pcnt", j),  32'(m_pcnt),  32'(tbl[j].pcnt));
            chk($sformatf("v%0d fcnt", j),  32'(m_fcnt),  32'(tbl[j].fcnt));
            chk($sformatf("v%0d ffv", j),   32'(m_ffv),   32'(tbl[j].ffv));
            chk($sformatf("v%0d ffs", j),   32'(m_ffs),   32'(tbl[j].ffs));
            chk($sformatf("v%0d ffst", j),  m_ffst,       tbl[j].ffst);
            chk($sformatf("v%0d sat_pcnt", j), 32'(s_pcnt), 32'(sat2(tbl[j].pcnt)));
            chk($sformatf("v%0d sat_fcnt", j), 32'(s_fcnt), 32'(sat2(tbl[j].fcnt)));
        end

        // N=3, DLY=2: odd offsets carry ev3=0 and must be ignored.
        rst = 1'b1; clr = 1'b0; en = 1'b1; trig = 1'b0; ev = 2'b00; ev3 = 3'b000;
        tick();
        rst = 1'b0; trig = 1'b1;
        tick();
        chk("long start pass", 32'(l_pass), 32'd0);
        trig = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            ev3 = (k % 2 == 0) ? 3'b111 : 3'b000;
            tick();
            chk($sformatf("long pass k%0d", k), 32'(l_pass), 32'(k == 6));
            chk($sformatf("long fail k%0d", k), 32'(l_fail), 32'd0);
        end
        chk("long pcnt", 32'(l_pcnt), 32'd1);

        // Second attempt (trigger stamp 8) fails at the last stage.
        trig = 1'b1; ev3 = 3'b000;
        tick();
        trig = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            ev3 = (k % 2 != 0) ? 3'b000 : ((k == 6) ? 3'b011 : 3'b111);
            tick();
            chk($sformatf("long2 pass k%0d", k), 32'(l_pass), 32'd0);
            chk($sformatf("long2 stage k%0d", k), 32'(l_stage), (k == 6) ? 32'd4 : 32'd0);
        end
        chk("long2 fcnt", 32'(l_fcnt), 32'd1);
        chk("long2 pcnt", 32'(l_pcnt), 32'd1);
        chk("long2 ffv",  32'(l_ffv),  32'd1);
        chk("long2 ffs",  32'(l_ffs),  32'd2);
        chk("long2 ffst", l_ffst,      32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
